spi_cmd_dispatcher: RTL

//  Sequences 24-bit SPI command frames into the config/control fabric. Frames are

---
 rtl/spi_cmd_dispatcher.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_dispatcher.sv
// spi_cmd_dispatcher: buffers 24-bit SPI command frames {cmd, addr, data} in a small FIFO
// and executes them one at a time as a config-bus write, a config-bus read or a trigger pulse.
// Optional feature: define SPI_CMD_TIMEOUT_EN to add a handshake watchdog on WRITE/READ.
module spi_cmd_dispatcher #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned NUM_TRIG       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [23:0]         frame_data_i,
  input  logic                frame_valid_i,
  output logic [ADDR_W-1:0]   cfg_addr_o,
  output logic [7:0]          cfg_wdata_o,
  output logic                cfg_wr_o,
  input  logic                cfg_ready_i,
  output logic                cfg_rd_o,
  input  logic [7:0]          cfg_rdata_i,
  input  logic                cfg_rd_ack_i,
  output logic [7:0]          tx_data_o,
  output logic                tx_data_valid_o,
  output logic [NUM_TRIG-1:0] trig_pulse_o,
  output logic                overflow_o,
  output logic [7:0]          err_count_o,
  output logic                busy_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [NUM_TRIG-1:0] TrigOne = NUM_TRIG'(1);

  typedef enum logic [2:0] {StIdle, StDecode, StWrite, StRead, StTrig} state_e;

  state_e              state_q, state_d;
  logic [23:0]         fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [23:0]         frame_q, frame_d;
  logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
  logic [7:0]          cfg_wdata_q, cfg_wdata_d;
  logic                cfg_wr_q, cfg_wr_d, cfg_rd_q, cfg_rd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [NUM_TRIG-1:0] trig_q, trig_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          err_q, err_d;
  logic                err_inc;

  logic fifo_empty, fifo_full, pop, push;
  logic [7:0] cur_cmd, cur_addr, cur_data;
  logic trig_ok;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  // Popping only happens from IDLE, so a pop always frees a slot for a same-cycle push.
  assign pop  = (state_q == StIdle) && !fifo_empty;
  assign push = frame_valid_i && (!fifo_full || pop);

  assign cur_cmd  = frame_q[23:16];
  assign cur_addr = frame_q[15:8];
  assign cur_data = frame_q[7:0];
  assign trig_ok  = ({1'b0, cur_addr} < 9'(NUM_TRIG));

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             timeout;

  // Watchdog counts cycles spent waiting for a handshake; cleared in every other state.
  always_comb begin
    wdog_d = '0;
    if ((state_q == StWrite) || (state_q == StRead)) wdog_d = wdog_q + WdogW'(1);
  end
  assign timeout = (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));

  // Watchdog register.
  always_ff @(posedge clk_i) begin
    if (reset_i) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`endif

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (frame_valid_i && fifo_full && !pop);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= frame_data_i;
  end

  // Command FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    cfg_wr_d    = cfg_wr_q;
    cfg_rd_d    = cfg_rd_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    trig_d      = '0;
    err_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          frame_d = fifo_q[rd_ptr_q];
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (cur_cmd == 8'h01) begin
          cfg_addr_d  = ADDR_W'(cur_addr);
          cfg_wdata_d = cur_data;
          cfg_wr_d    = 1'b1;
          state_d     = StWrite;
        end else if (cur_cmd == 8'h02) begin
          cfg_addr_d = ADDR_W'(cur_addr);
          cfg_rd_d   = 1'b1;
          state_d    = StRead;
        end else if ((cur_cmd == 8'h03) && trig_ok) begin
          trig_d  = TrigOne << cur_addr;
          state_d = StTrig;
        end else begin
          err_inc = 1'b1;
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (cfg_ready_i) begin
          cfg_wr_d = 1'b0;
          state_d  = StIdle;
`ifdef SPI_CMD_TIMEOUT_EN
        end else if (timeout) begin
          cfg_wr_d = 1'b0;
          err_inc  = 1'b1;
          state_d  = StIdle;
`endif
        end
      end
      StRead: begin
        if (cfg_rd_ack_i) begin
          tx_data_d  = cfg_rdata_i;
          tx_valid_d = 1'b1;
          cfg_rd_d   = 1'b0;
          state_d    = StIdle;
`ifdef SPI_CMD_TIMEOUT_EN
        end else if (timeout) begin
          cfg_rd_d = 1'b0;
          err_inc  = 1'b1;
          state_d  = StIdle;
`endif
        end
      end
      StTrig:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // State and output registers; reset aborts any transaction and empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_q     <= '0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      cfg_wr_q    <= 1'b0;
      cfg_rd_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      trig_q      <= '0;
      overflow_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      cfg_wr_q    <= cfg_wr_d;
      cfg_rd_q    <= cfg_rd_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      trig_q      <= trig_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  assign cfg_addr_o      = cfg_addr_q;
  assign cfg_wdata_o     = cfg_wdata_q;
  assign cfg_wr_o        = cfg_wr_q;
  assign cfg_rd_o        = cfg_rd_q;
  assign tx_data_o       = tx_data_q;
  assign tx_data_valid_o = tx_valid_q;
  assign trig_pulse_o    = trig_q;
  assign overflow_o      = overflow_q;
  assign err_count_o     = err_q;
  assign busy_o          = (state_q != StIdle) || !fifo_empty;

endmodule
